// File: rtl/reg_dump_unit.sv
// reg_dump_unit
// Read-side sequencer for the 8x8 register file. On a START request it walks
// a contiguous, wrapping address range [FIRST_ADDR .. LAST_ADDR] through one
// register-file read port. It captures each register value and streams
// {address, data} words out over a valid/ready handshake. It also keeps an
// 8-bit modulo checksum of the words emitted. It is the debug/scan-out path
// beside the CPU datapath, so it never touches the write side.
//
// Ports:
//   CLK         clock, all state updates on the rising edge
//   RESET       synchronous, active-high reset (highest priority)
//   START       dump request, only looked at in IDLE
//   FIRST_ADDR  first register of the range, latched when START is accepted
//   LAST_ADDR   last register of the range, latched when START is accepted
//   RD_ADDR     register-file read address
//   RD_DATA     register-file read data
//   OUT_VALID   output word valid
//   OUT_READY   consumer ready
//   OUT_ADDR    address of the word on OUT_DATA
//   OUT_DATA    captured register value
//   BUSY        high from START accept until the final handshake
//   DONE        one-cycle pulse after the final handshake
//   CHECKSUM    running sum mod 2^DATA_W of the words of the current/last dump
//
// Parameters:
//   DATA_W     register / output data width
//   ADDR_W     register address width (range wraps at 2^ADDR_W)
//   READ_WAIT  clock edges between driving RD_ADDR and sampling RD_DATA (>= 1)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for START; outputs hold their last values
// SETTLE | RD_ADDR driven, counting READ_WAIT edges for the read path
// SEND   | captured word presented on OUT_*, waiting for the handshake

module reg_dump_unit #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int READ_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] FIRST_ADDR,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [ADDR_W-1:0] OUT_ADDR,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] CHECKSUM
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    // The counter only ever needs to reach READ_WAIT-1.
    localparam int CNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_WAIT - 1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic [ADDR_W-1:0]  last_q,      last_d;
    logic [ADDR_W-1:0]  rd_addr_q,   rd_addr_d;
    logic [ADDR_W-1:0]  out_addr_q,  out_addr_d;
    logic [DATA_W-1:0]  out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [DATA_W-1:0]  checksum_q,  checksum_d;

    logic               handshake;
    logic               wait_done;
    logic               at_last;

    assign handshake = out_valid_q & OUT_READY;
    assign wait_done = (wait_cnt_q == CNT_LAST);
    assign at_last   = (rd_addr_q == last_q);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            last_q      <= '0;
            rd_addr_q   <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            last_q      <= last_d;
            rd_addr_q   <= rd_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (wait_done) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    state_d = at_last ? ST_IDLE : ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / output logic
    // ------------------------------------------------------------------
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        last_d      = last_q;
        rd_addr_d   = rd_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        checksum_d  = checksum_q;

        case (state_q)
            ST_IDLE: begin
                // FIRST_ADDR only seeds the read pointer, so it needs no
                // register of its own; LAST_ADDR is kept for the end compare.
                if (START) begin
                    last_d     = LAST_ADDR;
                    rd_addr_d  = FIRST_ADDR;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    wait_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (wait_done) begin
                    // Snapshot: later register-file writes cannot reach
                    // OUT_DATA because it is only loaded here.
                    out_data_d  = RD_DATA;
                    out_addr_d  = rd_addr_q;
                    out_valid_d = 1'b1;
                    checksum_d  = checksum_q + RD_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    if (at_last) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        // Natural ADDR_W overflow gives the wrap to 0.
                        rd_addr_d  = rd_addr_q + ADDR_W'(1);
                        wait_cnt_d = '0;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign RD_ADDR   = rd_addr_q;
    assign OUT_ADDR  = out_addr_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign CHECKSUM  = checksum_q;

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
Read-side sequencer for the 8x8 register file. On a START request it walks a contiguous, wrapping address range through one register-file read port. It captures each register value and streams {address, data} words out over a valid/ready handshake. It also accumulates an 8-bit modulo checksum. It serves as the debug/scan-out path beside the CPU datapath, so register state can be dumped without stalling the writer side.

Parameters:
DATA_W, 8, width of a register and of output data
ADDR_W, 3, register address width; range size is 2^ADDR_W
READ_WAIT, 1, clock edges between driving RD_ADDR and sampling RD_DATA; must be >=1, and covers the register file's read-path delay

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  dump request, sampled only in IDLE
FIRST_ADDR  input  ADDR_W  first register to dump, latched on START accept
LAST_ADDR  input  ADDR_W  last register to dump, latched on START accept
RD_ADDR  output  ADDR_W  drives register-file read address
RD_DATA  input  DATA_W  register-file read data
OUT_VALID  output  1  output word valid
OUT_READY  input  1  consumer ready
OUT_ADDR  output  ADDR_W  address of the word on OUT_DATA
OUT_DATA  output  DATA_W  captured register value
BUSY  output  1  high from START accept until final handshake
DONE  output  1  one-cycle pulse after final handshake
CHECKSUM  output  DATA_W  sum mod 2^DATA_W of words emitted in current/last dump

Behaviour:
- Reset (RESET=1 at a rising edge): state IDLE, wait counter 0.
  - RD_ADDR, OUT_ADDR, OUT_DATA, CHECKSUM = 0.
  - OUT_VALID, BUSY, DONE = 0.
  - Reset has priority over all other inputs.
  - Reset mid-dump aborts immediately; any pending word is dropped and no DONE is issued.
- States: IDLE, SETTLE, SEND.
- IDLE, START=1:
  - latch FIRST/LAST into internal regs; RD_ADDR<=FIRST_ADDR
  - CHECKSUM<=0, BUSY<=1, wait counter<=0
  - go to SETTLE
- IDLE, START=0: all outputs hold.
- SETTLE:
  - wait counter increments each edge.
  - On the edge where counter==READ_WAIT-1: OUT_DATA<=RD_DATA, OUT_ADDR<=RD_ADDR, OUT_VALID<=1, CHECKSUM<=CHECKSUM+RD_DATA (truncated), go to SEND.
- SEND:
  - OUT_VALID, OUT_ADDR and OUT_DATA hold stable while OUT_READY=0.
  - Handshake = OUT_VALID & OUT_READY at a rising edge; on it, OUT_VALID<=0.
    - If RD_ADDR==latched LAST: BUSY<=0, DONE<=1, go to IDLE.
    - Else: RD_ADDR<=RD_ADDR+1 (wraps 2^ADDR_W-1 -> 0), counter<=0, go to SETTLE.
- DONE is high for exactly one cycle. START is accepted in that same cycle, since state is IDLE.
- Word count = ((LAST-FIRST) mod 2^ADDR_W)+1.
  - FIRST==LAST: one word.
  - FIRST>LAST wraps, e.g. 6..1 emits 6,7,0,1.
- START while BUSY is ignored. FIRST_ADDR/LAST_ADDR changes during a dump are ignored.
- Latency: START accepted at edge n -> OUT_VALID high after edge n+READ_WAIT. With OUT_READY tied high, one word per READ_WAIT+1 cycles.
- Data is a snapshot taken at the capture edge. Register-file writes after capture do not alter OUT_DATA.
- CHECKSUM holds its final value after DONE until the next START accept.
- RD_ADDR holds its last value while IDLE.

Test Plan:
- Full dump, READ_WAIT=1:
  - Stimulus: R0..R7=0x10..0x17, FIRST=0, LAST=7, OUT_READY=1, START at edge 0.
  - Required: OUT_VALID after edges 1,3,...,15 with (addr,data)=(0,0x10)..(7,0x17); DONE pulse after edge 16; CHECKSUM=0x9C; BUSY low after edge 16.
- Wrap range:
  - Stimulus: FIRST=6, LAST=1, R6=0xFF, R7=0x01, R0=0x80, R1=0x80.
  - Required: words in order 6,7,0,1; CHECKSUM=0x00 (mod 256).
- Backpressure:
  - Stimulus: OUT_READY=0 for 5 cycles on the second word.
  - Required: OUT_VALID, OUT_ADDR=1 and OUT_DATA held stable all 5 cycles; no word lost or duplicated; total 8 words.
- Single word and re-start:
  - Stimulus: FIRST=LAST=3, R3=0x5A; START held high continuously.
  - Required: one word (3,0x5A), DONE pulse, new dump accepted in the DONE cycle; START ignored while BUSY.
- Reset mid-dump:
  - Stimulus: RESET=1 at an edge while in SEND with OUT_VALID=1.
  - Required: next cycle all outputs 0, state IDLE, no DONE pulse; a following START performs a clean full dump.
- Snapshot:
  - Stimulus: write R2 from 0x22 to 0x99 one cycle after word 2 is captured, OUT_READY=0.
  - Required: OUT_DATA stays 0x22 until handshake.
